pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer
// ----------------------------------------------------------------------------
// Program-counter sequencer sitting between an instruction memory and a core.
// It fetches one instruction word at a time from pc_out, presents it to the
// core until the core accepts it, then advances the PC (sequentially or by a
// jump/branch redirect) and fetches again. A dedicated HALT_WORD stops
// sequencing, and a fetch that waits too long for memory raises a timeout.
//
// Ports
//   clk            in   single clock, all state changes on the rising edge
//   reset_pc       in   asynchronous active-high reset
//   start          in   (re)start sequencing at pc_in (word aligned)
//   pc_in          in   start address
//   imem_req       out  fetch request, high only while fetching
//   imem_addr      out  fetch address, always equal to pc_out
//   imem_ack       in   fetch data valid this cycle
//   imem_data      in   fetched instruction word
//   stall          in   core cannot take an instruction this cycle
//   jump           in   unconditional redirect on accept
//   jump_target    in   jump destination
//   branch_taken   in   conditional redirect on accept (below jump)
//   branch_target  in   branch destination
//   instr_out      out  instruction presented to the core
//   instr_valid    out  instr_out is valid (issue phase)
//   pc_out         out  current PC
//   busy           out  fetching or issuing
//   halted         out  halt word has been accepted
//   timeout_err    out  fetch timed out waiting for imem_ack
//   retired        out  count of accepted instructions (wraps)
// ============================================================================
module pc_sequencer #(
   parameter int          ADDRESS_INSTRUCCION = 32,
   parameter int          MAX_WAIT            = 15,
   parameter logic [31:0] HALT_WORD           = 32'h0000000C
) (
   input  logic                           clk,
   input  logic                           reset_pc,
   input  logic                           start,
   input  logic [ADDRESS_INSTRUCCION-1:0] pc_in,
   output logic                           imem_req,
   output logic [ADDRESS_INSTRUCCION-1:0] imem_addr,
   input  logic                           imem_ack,
   input  logic [31:0]                    imem_data,
   input  logic                           stall,
   input  logic                           jump,
   input  logic [ADDRESS_INSTRUCCION-1:0] jump_target,
   input  logic                           branch_taken,
   input  logic [ADDRESS_INSTRUCCION-1:0] branch_target,
   output logic [31:0]                    instr_out,
   output logic                           instr_valid,
   output logic [ADDRESS_INSTRUCCION-1:0] pc_out,
   output logic                           busy,
   output logic                           halted,
   output logic                           timeout_err,
   output logic [31:0]                    retired
);

   localparam int AI     = ADDRESS_INSTRUCCION;
   localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   // Value of the wait counter during the last fetch cycle that may still
   // receive an ack; missing the ack in that cycle means the counter reaches
   // MAX_WAIT and the fetch is abandoned.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      ISSUE  = 3'd2,
      HALTED = 3'd3,
      ERROR  = 3'd4
   } state_t;

   state_t              state_reg;
   logic [WAIT_W-1:0]   wait_cnt_reg;
   logic [AI-1:0]       pc_next;
   logic [AI-1:0]       start_pc;
   logic                accept;
   logic                unused_bits;

   // Targets and start address are word aligned; their low bits are dropped.
   assign start_pc    = {pc_in[AI-1:2], 2'b00};
   assign unused_bits = ^{pc_in[1:0], jump_target[1:0], branch_target[1:0]};

   assign imem_addr = pc_out;
   assign accept    = (state_reg == ISSUE) && instr_valid && !stall;

   // PC after a non-halt accept: jump beats branch beats sequential.
   // The sequential add wraps naturally at the address width.
   always_comb begin
      pc_next = pc_out + AI'(4);
      if (jump) begin
         pc_next = {jump_target[AI-1:2], 2'b00};
      end else if (branch_taken) begin
         pc_next = {branch_target[AI-1:2], 2'b00};
      end
   end

   always_ff @(posedge clk or posedge reset_pc) begin
      if (reset_pc) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= '0;
         pc_out       <= '0;
         instr_out    <= '0;
         retired      <= '0;
         imem_req     <= 1'b0;
         instr_valid  <= 1'b0;
         busy         <= 1'b0;
         halted       <= 1'b0;
         timeout_err  <= 1'b0;
      end else if (start) begin
         // Restart from any state; an accept in this same cycle is dropped,
         // so the retire count is left untouched.
         state_reg    <= FETCH;
         wait_cnt_reg <= '0;
         pc_out       <= start_pc;
         imem_req     <= 1'b1;
         instr_valid  <= 1'b0;
         busy         <= 1'b1;
         halted       <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         case (state_reg)
            FETCH: begin
               if (imem_ack) begin
                  // An ack in the final allowed cycle still wins over timeout.
                  instr_out   <= imem_data;
                  state_reg   <= ISSUE;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
                  state_reg    <= ERROR;
                  imem_req     <= 1'b0;
                  busy         <= 1'b0;
                  timeout_err  <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end

            ISSUE: begin
               // While stalled everything, including instr_out and PC, holds.
               if (accept) begin
                  retired     <= retired + 32'd1;
                  instr_valid <= 1'b0;
                  if (instr_out == HALT_WORD) begin
                     // Halt keeps the PC where it is and ignores redirects.
                     state_reg <= HALTED;
                     busy      <= 1'b0;
                     halted    <= 1'b1;
                  end else begin
                     pc_out       <= pc_next;
                     state_reg    <= FETCH;
                     wait_cnt_reg <= '0;
                     imem_req     <= 1'b1;
                  end
               end
            end

            // IDLE, HALTED and ERROR wait for start or reset.
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for pc_sequencer. A transaction-level reference model
// (phase + PC + captured word + retire count) is advanced once per clock edge
// from the same inputs the DUT sees, and every output is compared 1 time unit
// after the edge. Directed scenarios come first, then randomized traffic.
// ============================================================================
module tb_pc_sequencer;

   localparam int          AW   = 32;
   localparam int          MAXW = 15;
   localparam logic [31:0] HALT = 32'h0000000C;

   logic          clk;
   logic          reset_pc;
   logic          start;
   logic [AW-1:0] pc_in;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [31:0]   imem_data;
   logic          stall;
   logic          jump;
   logic [AW-1:0] jump_target;
   logic          branch_taken;
   logic [AW-1:0] branch_target;
   logic [31:0]   instr_out;
   logic          instr_valid;
   logic [AW-1:0] pc_out;
   logic          busy;
   logic          halted;
   logic          timeout_err;
   logic [31:0]   retired;

   pc_sequencer #(
      .ADDRESS_INSTRUCCION(AW),
      .MAX_WAIT(MAXW),
      .HALT_WORD(HALT)
   ) dut (
      .clk(clk),
      .reset_pc(reset_pc),
      .start(start),
      .pc_in(pc_in),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_data(imem_data),
      .stall(stall),
      .jump(jump),
      .jump_target(jump_target),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .instr_out(instr_out),
      .instr_valid(instr_valid),
      .pc_out(pc_out),
      .busy(busy),
      .halted(halted),
      .timeout_err(timeout_err),
      .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_OFF, M_WAITING, M_HOLDING, M_STOPPED, M_FAILED} mphase_t;
   mphase_t     m_phase;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_ret;
   int          m_age;
   logic        m_terr;

   task automatic model_reset();
      m_phase = M_OFF;
      m_pc    = '0;
      m_instr = '0;
      m_ret   = '0;
      m_age   = 0;
      m_terr  = 1'b0;
   endtask

   // One clock edge of behaviour, written from the sequencing rules.
   task automatic model_edge();
      if (reset_pc) begin
         model_reset();
      end else if (start) begin
         m_pc    = pc_in & ~32'h3;
         m_phase = M_WAITING;
         m_age   = 0;
         m_terr  = 1'b0;
      end else begin
         case (m_phase)
            M_WAITING: begin
               m_age++;
               if (imem_ack) begin
                  m_instr = imem_data;
                  m_phase = M_HOLDING;
               end else if (m_age >= MAXW) begin
                  m_phase = M_FAILED;
                  m_terr  = 1'b1;
               end
            end
            M_HOLDING: begin
               if (!stall) begin
                  m_ret = m_ret + 1;
                  if (m_instr == HALT) begin
                     m_phase = M_STOPPED;
                  end else begin
                     if (jump)              m_pc = jump_target & ~32'h3;
                     else if (branch_taken) m_pc = branch_target & ~32'h3;
                     else                   m_pc = m_pc + 32'd4;
                     m_phase = M_WAITING;
                     m_age   = 0;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic compare_all(input string w);
      check_val({w, ".pc"},      pc_out,      m_pc);
      check_val({w, ".addr"},    imem_addr,   m_pc);
      check_val({w, ".instr"},   instr_out,   m_instr);
      check_val({w, ".retired"}, retired,     m_ret);
      check_val({w, ".req"},     32'(imem_req),    32'(m_phase == M_WAITING));
      check_val({w, ".valid"},   32'(instr_valid), 32'(m_phase == M_HOLDING));
      check_val({w, ".busy"},    32'(busy),
                32'((m_phase == M_WAITING) || (m_phase == M_HOLDING)));
      check_val({w, ".halted"},  32'(halted),      32'(m_phase == M_STOPPED));
      check_val({w, ".tmo"},     32'(timeout_err), 32'(m_terr));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all("cyc");
   endtask

   task automatic clr_inputs();
      start         = 1'b0;
      pc_in         = '0;
      imem_ack      = 1'b0;
      imem_data     = '0;
      stall         = 1'b0;
      jump          = 1'b0;
      jump_target   = '0;
      branch_taken  = 1'b0;
      branch_target = '0;
   endtask

   // Reset asserted between edges must clear outputs before the next edge.
   task automatic async_reset_pulse(input logic start_during);
      reset_pc = 1'b1;
      start    = start_during;
      #1;
      model_reset();
      compare_all("arst");
      step();
      reset_pc = 1'b0;
      start    = 1'b0;
   endtask

   int ack_pct;

   initial begin
      clr_inputs();
      reset_pc = 1'b1;
      model_reset();
      step();
      step();
      check_val("reset.req", 32'(imem_req), 32'd0);
      reset_pc = 1'b0;
      step();

      // Start at unaligned 0x103, ack after two waits, no stall.
      start = 1'b1; pc_in = 32'h103;
      step();
      start = 1'b0;
      check_val("r37.addr", imem_addr, 32'h100);
      step();
      step();
      imem_ack = 1'b1; imem_data = 32'h20080005;
      step();
      imem_ack = 1'b0;
      check_val("r37.valid", 32'(instr_valid), 32'd1);
      check_val("r37.instr", instr_out, 32'h20080005);
      step();
      check_val("r37.valid_drop", 32'(instr_valid), 32'd0);
      check_val("r37.retired", retired, 32'd1);
      check_val("r37.next_addr", imem_addr, 32'h104);

      // Stall three cycles with a jump present, release with a branch.
      imem_ack = 1'b1; imem_data = 32'h00A00093;
      step();
      imem_ack = 1'b0;
      stall = 1'b1; jump = 1'b1; jump_target = 32'h80;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("r38.hold_pc", pc_out, 32'h104);
         check_val("r38.hold_valid", 32'(instr_valid), 32'd1);
      end
      stall = 1'b0; jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
      step();
      branch_taken = 1'b0;
      check_val("r38.pc", pc_out, 32'h40);
      check_val("r38.retired", retired, 32'd2);

      // Jump beats branch.
      imem_ack = 1'b1; imem_data = 32'h11111111;
      step();
      imem_ack = 1'b0;
      jump = 1'b1; jump_target = 32'h200; branch_taken = 1'b1; branch_target = 32'h300;
      step();
      jump = 1'b0; branch_taken = 1'b0;
      check_val("r39.pc", pc_out, 32'h200);

      // Fetch timeout after MAXW ack-less cycles, then restart clears it.
      repeat (MAXW - 1) step();
      check_val("r40.not_yet", 32'(timeout_err), 32'd0);
      step();
      check_val("r40.tmo", 32'(timeout_err), 32'd1);
      check_val("r40.busy", 32'(busy), 32'd0);
      start = 1'b1; pc_in = 32'h10;
      step();
      start = 1'b0;
      check_val("r40.restart_tmo", 32'(timeout_err), 32'd0);
      check_val("r40.restart_req", 32'(imem_req), 32'd1);

      // PC wrap at the top of the space, then halt.
      start = 1'b1; pc_in = 32'hFFFFFFFC;
      step();
      start = 1'b0;
      imem_ack = 1'b1; imem_data = 32'h0;
      step();
      imem_ack = 1'b0;
      step();
      check_val("r41.wrap", pc_out, 32'h0);
      imem_ack = 1'b1; imem_data = HALT;
      step();
      imem_ack = 1'b0; jump = 1'b1; jump_target = 32'h500;
      step();
      jump = 1'b0;
      check_val("r41.halted", 32'(halted), 32'd1);
      check_val("r41.pc", pc_out, 32'h0);
      step();
      step();
      check_val("r41.hold", pc_out, 32'h0);

      // Reset mid-issue with five retired.
      start = 1'b1; pc_in = 32'h20;
      step();
      start = 1'b0;
      imem_ack = 1'b1; imem_data = 32'h13;
      step();
      imem_ack = 1'b0; stall = 1'b1;
      check_val("r42.pre_retired", retired, 32'd5);
      async_reset_pulse(1'b1);
      check_val("r42.retired", retired, 32'd0);
      check_val("r42.idle", 32'(busy), 32'd0);
      stall = 1'b0;
      step();
      check_val("r42.stay_idle", 32'(imem_req), 32'd0);

      // Randomized traffic.
      ack_pct = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 150 == 0) begin
            case ($urandom_range(0, 3))
               0:       ack_pct = 0;
               1:       ack_pct = 15;
               2:       ack_pct = 50;
               default: ack_pct = 90;
            endcase
         end
         if ($urandom_range(0, 199) == 0) begin
            async_reset_pulse(1'($urandom_range(0, 1)));
         end else begin
            if (m_phase == M_OFF || m_phase == M_STOPPED || m_phase == M_FAILED)
               start = ($urandom_range(0, 9) < 3);
            else
               start = ($urandom_range(0, 99) < 2);
            pc_in         = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                                        : $urandom;
            imem_ack      = ($urandom_range(0, 99) < ack_pct);
            imem_data     = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
            stall         = ($urandom_range(0, 99) < 35);
            jump          = ($urandom_range(0, 99) < 25);
            jump_target   = $urandom;
            branch_taken  = ($urandom_range(0, 99) < 35);
            branch_target = $urandom;
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
